// File: rtl/sr_stack_if.sv
// Port bundle for sr_stack: ALU/control strobes in, registered status out.
// sr_next exists only when SR_STACK_FWD_EN is defined.
interface sr_stack_if #(
  parameter int FLAGS = 4,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [FLAGS-1:0] flags_in;
  logic             ws;
  logic [FLAGS-1:0] wmask;
  logic             ld;
  logic [FLAGS-1:0] ld_data;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [FLAGS-1:0] sr_out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             err;

`ifdef SR_STACK_FWD_EN
  logic [FLAGS-1:0] sr_next;

  modport master (
    output flags_in, ws, wmask, ld, ld_data, push, pop, err_clr,
    input  sr_out, depth, full, empty, err, sr_next
  );

  modport slave (
    input  flags_in, ws, wmask, ld, ld_data, push, pop, err_clr,
    output sr_out, depth, full, empty, err, sr_next
  );
`else
  modport master (
    output flags_in, ws, wmask, ld, ld_data, push, pop, err_clr,
    input  sr_out, depth, full, empty, err
  );

  modport slave (
    input  flags_in, ws, wmask, ld, ld_data, push, pop, err_clr,
    output sr_out, depth, full, empty, err
  );
`endif
endinterface

// File: rtl/sr_stack.sv
// Status register with per-bit masked write, full-word load and a save/restore stack.
// Optional same-cycle forwarding of the next SR value when SR_STACK_FWD_EN is defined.
module sr_stack #(
  parameter int FLAGS = 4,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  sr_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAGS-1:0] sr_q;
  logic [FLAGS-1:0] sr_d;
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic             err_q;
  logic             err_d;
  logic [FLAGS-1:0] stack_mem [DEPTH];

  logic             is_full;
  logic             is_empty;
  logic             push_ok;
  logic             pop_ok;
  logic             new_err;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign wr_idx   = AW'(depth_q);
  assign top_idx  = AW'(depth_q - DW'(1));

  // A simultaneous push and pop is a misuse: neither takes effect.
  assign push_ok = bus.push && !bus.pop && !is_full;
  assign pop_ok  = bus.pop  && !bus.push && !is_empty;
  assign new_err = (bus.push && bus.pop)
                || (bus.push && !bus.pop && is_full)
                || (bus.pop  && !bus.push && is_empty);

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sr_d = sr_q;
    if (pop_ok) begin
      sr_d = stack_mem[top_idx];
    end else if (bus.ld) begin
      sr_d = bus.ld_data;
    end else if (bus.ws) begin
      sr_d = (sr_q & ~bus.wmask) | (bus.flags_in & bus.wmask);
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (new_err) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      stack_mem[wr_idx] <= sr_q;
    end
  end

  assign bus.sr_out = sr_q;
  assign bus.depth  = depth_q;
  assign bus.full   = is_full;
  assign bus.empty  = is_empty;
  assign bus.err    = err_q;

`ifdef SR_STACK_FWD_EN
  assign bus.sr_next = reset ? '0 : sr_d;
`endif

endmodule

// File: tb/tb_sr_stack.sv
// Directed bench for sr_stack: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sr_stack;
  localparam int FLAGS = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sr_stack_if #(.FLAGS(FLAGS), .DEPTH(DEPTH)) bus ();
  sr_stack #(.FLAGS(FLAGS), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: SR value, stack as a queue (back = top), sticky error.
  logic [FLAGS-1:0] m_sr;
  logic [FLAGS-1:0] m_stk[$];
  logic             m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [FLAGS-1:0] predict();
    logic [FLAGS-1:0] n;
    n = m_sr;
    if (bus.pop && !bus.push && m_stk.size() > 0) n = m_stk[m_stk.size()-1];
    else if (bus.ld) n = bus.ld_data;
    else if (bus.ws) begin
      for (int i = 0; i < FLAGS; i++)
        if (bus.wmask[i]) n[i] = bus.flags_in[i];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_sr  = '0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [FLAGS-1:0] n;
    bit do_push, do_pop, misuse;
    if (reset) begin
      model_reset();
      return;
    end
    n       = predict();
    do_push = bus.push && !bus.pop && m_stk.size() < DEPTH;
    do_pop  = bus.pop && !bus.push && m_stk.size() > 0;
    misuse  = (bus.push && bus.pop) || (bus.push && !bus.pop && m_stk.size() == DEPTH)
           || (bus.pop && !bus.push && m_stk.size() == 0);
    if (do_push) m_stk.push_back(m_sr);
    if (do_pop)  void'(m_stk.pop_back());
    if (misuse) m_err = 1'b1;
    else if (bus.err_clr) m_err = 1'b0;
    m_sr = n;
  endtask

  // Compare process: outputs are checked against the model on every falling edge.
  always @(negedge clk) begin
    check("sr_out", bus.sr_out, m_sr);
    check("depth", bus.depth, m_stk.size());
    check("full", bus.full, m_stk.size() == DEPTH);
    check("empty", bus.empty, m_stk.size() == 0);
    check("err", bus.err, m_err);
`ifdef SR_STACK_FWD_EN
    check("sr_next", bus.sr_next, reset ? '0 : predict());
`endif
  end

  task automatic idle();
    bus.flags_in = '0; bus.ws = 1'b0; bus.wmask = '0;
    bus.ld = 1'b0; bus.ld_data = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  // One clock: model follows the edge, then inputs may change just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_ws(input logic [FLAGS-1:0] f, input logic [FLAGS-1:0] m);
    idle(); bus.ws = 1'b1; bus.flags_in = f; bus.wmask = m; cyc();
  endtask

  task automatic do_ld_push(input logic [FLAGS-1:0] v, input bit p);
    idle(); bus.ld = 1'b1; bus.ld_data = v; bus.push = p; cyc();
  endtask

  task automatic do_pop();
    idle(); bus.pop = 1'b1; cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLAGS-1:0] exp_pops [4];
    exp_pops[0] = 4'b1000; exp_pops[1] = 4'b0100; exp_pops[2] = 4'b0010; exp_pops[3] = 4'b0001;

    reset = 1'b1;
    idle();
    model_reset();
    cyc(); cyc();
    check("reset_sr", bus.sr_out, 4'b0000);
    check("reset_depth", bus.depth, 0);
    check("reset_empty", bus.empty, 1'b1);
    check("reset_full", bus.full, 1'b0);
    reset = 1'b0;

    // Masked write
    do_ws(4'b1111, 4'b0101);
    check("masked_write", bus.sr_out, 4'b0101);

    // ld beats ws
    idle(); bus.ld = 1'b1; bus.ld_data = 4'b1010;
    bus.ws = 1'b1; bus.flags_in = 4'b0101; bus.wmask = 4'b1111; cyc();
    check("ld_priority", bus.sr_out, 4'b1010);

    // Partial mask holds unmasked bits
    do_ws(4'b0011, 4'b1111);
    do_ws(4'b1100, 4'b0100);
    check("partial_mask", bus.sr_out, 4'b0111);
    do_ws(4'b0011, 4'b1111);

    // push with ws: stack keeps pre-edge value
    idle(); bus.push = 1'b1; bus.ws = 1'b1; bus.flags_in = 4'b1100; bus.wmask = 4'b1111; cyc();
    check("push_ws_sr", bus.sr_out, 4'b1100);
    check("push_ws_depth", bus.depth, 1);
    do_pop();
    check("pop_restore", bus.sr_out, 4'b0011);
    check("pop_depth", bus.depth, 0);
    check("pop_empty", bus.empty, 1'b1);

    // Valid pop beats ld
    idle(); bus.push = 1'b1; cyc();
    idle(); bus.pop = 1'b1; bus.ld = 1'b1; bus.ld_data = 4'b1111; cyc();
    check("pop_over_ld", bus.sr_out, 4'b0011);

    // Fill: stack receives 0001,0010,0100,1000
    do_ld_push(4'b0001, 1'b0);
    do_ld_push(4'b0010, 1'b1);
    do_ld_push(4'b0100, 1'b1);
    do_ld_push(4'b1000, 1'b1);
    idle(); bus.push = 1'b1; cyc();
    check("fill_full", bus.full, 1'b1);
    check("fill_err", bus.err, 1'b0);
    check("fill_depth", bus.depth, 4);
    idle(); bus.push = 1'b1; cyc();
    check("overflow_depth", bus.depth, 4);
    check("overflow_err", bus.err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check($sformatf("pop_order_%0d", i), bus.sr_out, exp_pops[i]);
    end
    check("drain_empty", bus.empty, 1'b1);

    // Underflow and err_clr
    idle(); bus.err_clr = 1'b1; cyc();
    check("err_clr_1", bus.err, 1'b0);
    idle(); bus.pop = 1'b1; bus.ws = 1'b1; bus.flags_in = 4'b0110; bus.wmask = 4'b1111; cyc();
    check("underflow_sr", bus.sr_out, 4'b0110);
    check("underflow_err", bus.err, 1'b1);
    idle(); bus.err_clr = 1'b1; cyc();
    check("err_clr_2", bus.err, 1'b0);
    idle(); bus.err_clr = 1'b1; bus.push = 1'b1; bus.pop = 1'b1; cyc();
    check("err_beats_clr", bus.err, 1'b1);
    check("both_depth", bus.depth, 0);
    idle(); bus.err_clr = 1'b1; cyc();

    // Forwarding
    idle(); bus.ws = 1'b1; bus.flags_in = 4'b1001; bus.wmask = 4'b1111;
    #1;
`ifdef SR_STACK_FWD_EN
    check("fwd_same_cycle", bus.sr_next, 4'b1001);
`endif
    cyc();
    check("fwd_after_edge", bus.sr_out, 4'b1001);

    // Async reset between edges
    idle(); bus.push = 1'b1; cyc(); cyc();
    idle();
    check("pre_reset_depth", bus.depth, 2);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_sr", bus.sr_out, 4'b0000);
    check("async_depth", bus.depth, 0);
    check("async_empty", bus.empty, 1'b1);
    cyc();
    reset = 1'b0;
    do_ws(4'b0011, 4'b0011);
    check("post_reset_ws", bus.sr_out, 4'b0011);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
